// File: rtl/fft_frame_ctrl_if.sv
// Groups the sample stream, core drive/return and status signals of fft_frame_ctrl.
// Latency: none, wires only.
// Backpressure: none; in_ready only drops while the block is held in reset.
interface fft_frame_ctrl_if #(
  parameter int NBITS     = 10,
  parameter int NBITS_out = 19,
  parameter int N         = 128
);
  localparam int B  = N / 4;
  localparam int IW = $clog2(B);

  logic                   in_valid;
  logic                   in_sof;
  logic [8*NBITS-1:0]     in_data;
  logic                   in_ready;
  logic [8*NBITS-1:0]     core_in;
  logic [8*NBITS_out-1:0] core_out;
  logic [8*NBITS_out-1:0] out_data;
  logic                   out_valid;
  logic                   out_sof;
  logic                   out_eof;
  logic [IW-1:0]          out_idx;
  logic                   out_err;
  logic [15:0]            frame_cnt;
  logic [7:0]             err_cnt;
  logic                   busy;

  // Sequencer side.
  modport slave (
    input  in_valid, in_sof, in_data, core_out,
    output in_ready, core_in, out_data, out_valid, out_sof, out_eof,
           out_idx, out_err, frame_cnt, err_cnt, busy
  );

  // Source / core / consumer side.
  modport master (
    output in_valid, in_sof, in_data, core_out,
    input  in_ready, core_in, out_data, out_valid, out_sof, out_eof,
           out_idx, out_err, frame_cnt, err_cnt, busy
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: turns a valid/SOF sample stream into contiguous B-beat frames for a free-running FFT core.
// Latency: core_in one clock after acceptance; out_* tags LAT clocks later, aligned with core_out.
// Backpressure: none; every beat is consumed, underruns zero-fill and flag the frame as errored.
module fft_frame_ctrl #(
  parameter int NBITS     = 10,
  parameter int NBITS_out = 19,
  parameter int N         = 128,
  parameter int LAT       = 9
) (
  input  logic            clk,
  input  logic            rst,
  fft_frame_ctrl_if.slave bus
);
  localparam int            B    = N / 4;
  localparam int            IW   = $clog2(B);
  localparam logic [IW-1:0] LAST = IW'(B - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ABORT = 2'd2} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IW-1:0]          r_cnt;
  logic [IW-1:0]          w_cnt_nxt;
  logic                   r_frame_err;
  logic                   w_frame_err_nxt;
  logic [8*NBITS-1:0]     r_core_in;
  logic [8*NBITS-1:0]     w_core_in_nxt;
  logic                   w_last;
  logic                   w_tag_vld;
  logic [IW-1:0]          w_tag_idx;
  logic                   w_tag_err;

  logic [LAT:0]           r_tag_vld;
  logic [LAT:0]           r_tag_err;
  logic [IW-1:0]          r_tag_idx [0:LAT];

  logic [15:0]            r_frame_cnt;
  logic [7:0]             r_err_cnt;
  logic                   w_out_vld;
  logic                   w_out_eof;
  logic                   w_out_err;
  logic [8*NBITS_out-1:0] w_out_data;

  assign w_last = (r_cnt == LAST);

  // Next state, core drive and the tag launched alongside the beat.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_frame_err_nxt = r_frame_err;
    w_core_in_nxt   = '0;
    w_tag_vld       = 1'b0;
    w_tag_idx       = r_cnt;
    w_tag_err       = 1'b0;
    case (r_state)
      IDLE: begin
        // Non-SOF beats are swallowed here; B>=2 so beat 0 is never EOF.
        if (bus.in_valid && bus.in_sof) begin
          w_core_in_nxt   = bus.in_data;
          w_tag_vld       = 1'b1;
          w_tag_idx       = '0;
          w_cnt_nxt       = IW'(1);
          w_frame_err_nxt = 1'b0;
          w_state_nxt     = RUN;
        end
      end
      RUN: begin
        w_tag_vld = 1'b1;
        if (bus.in_valid) begin
          w_core_in_nxt = bus.in_data;
        end else begin
          w_frame_err_nxt = 1'b1;
        end
        // An underrun on the last beat still marks this frame bad.
        w_tag_err = w_last && (r_frame_err || !bus.in_valid);
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + IW'(1);
          w_state_nxt = bus.in_valid ? RUN : ABORT;
        end
      end
      ABORT: begin
        // Keep the core frame contiguous with zeros; input is discarded.
        w_tag_vld = 1'b1;
        w_tag_err = w_last && r_frame_err;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + IW'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state and registered core drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
      r_core_in   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_core_in   <= w_core_in_nxt;
    end
  end

  // Tag pipe: stage 0 loads with core_in, stage LAT lines up with core_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_vld <= '0;
      r_tag_err <= '0;
      for (int i = 0; i <= LAT; i++) r_tag_idx[i] <= '0;
    end else begin
      r_tag_vld    <= {r_tag_vld[LAT-1:0], w_tag_vld};
      r_tag_err    <= {r_tag_err[LAT-1:0], w_tag_err};
      r_tag_idx[0] <= w_tag_idx;
      for (int i = 1; i <= LAT; i++) r_tag_idx[i] <= r_tag_idx[i-1];
    end
  end

  assign w_out_vld  = r_tag_vld[LAT];
  assign w_out_eof  = w_out_vld && (r_tag_idx[LAT] == LAST);
  assign w_out_err  = w_out_eof && r_tag_err[LAT];
  assign w_out_data = w_out_vld ? bus.core_out : '0;

  // Frame statistics at each emitted EOF: good frames wrap, errored frames saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_out_eof) begin
      if (w_out_err) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign bus.in_ready  = rst;
  assign bus.core_in   = r_core_in;
  assign bus.out_data  = w_out_data;
  assign bus.out_valid = w_out_vld;
  assign bus.out_sof   = w_out_vld && (r_tag_idx[LAT] == '0);
  assign bus.out_eof   = w_out_eof;
  assign bus.out_idx   = w_out_vld ? r_tag_idx[LAT] : '0;
  assign bus.out_err   = w_out_err;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.busy      = (r_state != IDLE) || (|r_tag_vld);
endmodule
